// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM vector adder: FSM encoding,
// word size and signed saturation limits.
package bram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_B,
      ST_CAPT,
      ST_WR,
      ST_DONE
   } state_t;

   localparam int          WORD_BYTES = 4;
   localparam logic [31:0] SAT_MAX    = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/vec_add32.sv
// 32-bit element adder: modulo 2^32 by default, signed saturating
// when BRAM_VEC_SAT_EN is defined.
module vec_add32
   import bram_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   logic [31:0] raw;

   assign raw = a + b;

`ifdef BRAM_VEC_SAT_EN
   logic ovf;

   // Overflow only when both operands share a sign the result lacks
   assign ovf = (a[31] == b[31]) && (raw[31] != a[31]);
   assign sum = ovf ? (a[31] ? SAT_MIN : SAT_MAX) : raw;
`else
   assign sum = raw;
`endif

endmodule

// File: rtl/bram_vec_adder.sv
// C[i] = A[i] + B[i] over a single BRAM port, 4 cycles per element.
// Define BRAM_VEC_SAT_EN for signed saturating addition.
module bram_vec_adder
   import bram_pkg::*;
#(
   parameter int BRAM_ADDR_WIDTH = 15,
   parameter int MAX_LEN_WIDTH   = 14
) (
   input  logic                       BRAM_CLK,
   input  logic                       BRAM_RST,
   input  logic                       start,
   input  logic [MAX_LEN_WIDTH-1:0]   len,
   input  logic [BRAM_ADDR_WIDTH-1:0] base_a,
   input  logic [BRAM_ADDR_WIDTH-1:0] base_b,
   input  logic [BRAM_ADDR_WIDTH-1:0] base_c,
   output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic [31:0]                BRAM_WRDATA,
   input  logic [31:0]                BRAM_RDDATA,
   output logic                       BRAM_EN,
   output logic [3:0]                 BRAM_WE,
   output logic                       busy,
   output logic                       done
);

   localparam logic [BRAM_ADDR_WIDTH-1:0] STEP =
      BRAM_ADDR_WIDTH'(WORD_BYTES);

   state_t                     state;
   state_t                     nstate;
   logic [BRAM_ADDR_WIDTH-1:0] a_ptr;
   logic [BRAM_ADDR_WIDTH-1:0] b_ptr;
   logic [BRAM_ADDR_WIDTH-1:0] c_ptr;
   logic [BRAM_ADDR_WIDTH-1:0] addr_q;
   logic [BRAM_ADDR_WIDTH-1:0] addr_d;
   logic [MAX_LEN_WIDTH-1:0]   rem_q;
   logic [31:0]                a_q;
   logic [31:0]                sum_q;
   logic [31:0]                sum_d;
   logic                       accept;
   logic                       en_d;
   logic [3:0]                 we_d;

   vec_add32 u_add (
      .a   (a_q),
      .b   (BRAM_RDDATA),
      .sum (sum_d)
   );

   assign accept = start && (state == ST_IDLE || state == ST_DONE);

   always_comb begin
      nstate = state;
      addr_d = addr_q;
      en_d   = 1'b0;
      we_d   = 4'h0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start)
               nstate = (len != '0) ? ST_RD_A : ST_DONE;
         end
         ST_RD_A: begin
            addr_d = a_ptr;
            en_d   = 1'b1;
            nstate = ST_RD_B;
         end
         ST_RD_B: begin
            addr_d = b_ptr;
            en_d   = 1'b1;
            nstate = ST_CAPT;
         end
         ST_CAPT: nstate = ST_WR;
         ST_WR: begin
            addr_d = c_ptr;
            en_d   = 1'b1;
            we_d   = 4'hF;
            nstate = (rem_q == MAX_LEN_WIDTH'(1)) ? ST_DONE : ST_RD_A;
         end
         default: nstate = ST_IDLE;
      endcase
   end

   // Reset suppresses the port at once so an aborted write never lands
   assign BRAM_ADDR   = addr_d;
   assign BRAM_EN     = en_d & ~BRAM_RST;
   assign BRAM_WE     = BRAM_RST ? 4'h0 : we_d;
   assign BRAM_WRDATA = sum_q;
   assign busy        = (state == ST_RD_A) || (state == ST_RD_B) ||
                        (state == ST_CAPT) || (state == ST_WR);
   assign done        = (state == ST_DONE);

   always_ff @(posedge BRAM_CLK) begin
      if (BRAM_RST) begin
         state  <= ST_IDLE;
         addr_q <= '0;
         a_ptr  <= '0;
         b_ptr  <= '0;
         c_ptr  <= '0;
         rem_q  <= '0;
         a_q    <= '0;
         sum_q  <= '0;
      end else begin
         state  <= nstate;
         addr_q <= addr_d;
         if (accept) begin
            a_ptr <= {base_a[BRAM_ADDR_WIDTH-1:2], 2'b00};
            b_ptr <= {base_b[BRAM_ADDR_WIDTH-1:2], 2'b00};
            c_ptr <= {base_c[BRAM_ADDR_WIDTH-1:2], 2'b00};
            rem_q <= len;
         end
         if (state == ST_RD_B)
            a_q <= BRAM_RDDATA;
         if (state == ST_CAPT)
            sum_q <= sum_d;
         if (state == ST_WR) begin
            a_ptr <= a_ptr + STEP;
            b_ptr <= b_ptr + STEP;
            c_ptr <= c_ptr + STEP;
            rem_q <= rem_q - MAX_LEN_WIDTH'(1);
         end
      end
   end

endmodule

// File: doc/bram_vec_adder.md
BRAM_VEC_ADDER -- requirements
Module: bram_vec_adder

Interface
REQ-001 Parameter BRAM_ADDR_WIDTH, default 15: byte-address width of the BRAM port (8192 x 32-bit words).
REQ-002 Parameter MAX_LEN_WIDTH, default 14: width of the element-count input.
REQ-003 BRAM_CLK  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 BRAM_RST  input  1: synchronous, active-high reset.
REQ-005 start  input  1: one-cycle request to begin an operation; sampled only in IDLE.
REQ-006 len  input  MAX_LEN_WIDTH: element count, latched on accepted start.
REQ-007 base_a, base_b, base_c  input  BRAM_ADDR_WIDTH each: byte base addresses of source A, source B and destination C, latched on accepted start.
REQ-008 BRAM_ADDR  output  BRAM_ADDR_WIDTH: byte address to the BRAM responder.
REQ-009 BRAM_WRDATA  output  32: write data.
REQ-010 BRAM_RDDATA  input  32: read data, registered by the responder one edge after a read request.
REQ-011 BRAM_EN  output  1: port enable.
REQ-012 BRAM_WE  output  4: per-byte write enables; 4'h0 means read.
REQ-013 busy  output  1: high from the cycle after an accepted start until DONE is entered.
REQ-014 done  output  1: level completion flag.

Function
REQ-015 The block SHALL compute C[i] = A[i] + B[i] for i = 0..len-1, where X[i] is the word at byte address base_x + 4*i.
REQ-016 Latched bases SHALL have bits [1:0] forced to 0; address arithmetic SHALL wrap modulo 2^BRAM_ADDR_WIDTH.
REQ-017 FSM states SHALL be IDLE, RD_A, RD_B, CAPT, WR, DONE.
REQ-018 IDLE: start=1 with len!=0 -> RD_A; start=1 with len=0 -> DONE; otherwise remain.
REQ-019 RD_A: BRAM_ADDR=A address, BRAM_EN=1, BRAM_WE=0 -> RD_B.
REQ-020 RD_B: BRAM_ADDR=B address, BRAM_EN=1, BRAM_WE=0; BRAM_RDDATA (=A[i]) SHALL be registered at the end of this cycle -> CAPT.
REQ-021 CAPT: BRAM_EN=0; sum of the registered A[i] and BRAM_RDDATA (=B[i]) SHALL be registered -> WR.
REQ-022 WR: BRAM_ADDR=C address, BRAM_EN=1, BRAM_WE=4'hF, BRAM_WRDATA=registered sum; index increments; last element -> DONE, else -> RD_A.
REQ-023 Throughput SHALL be exactly 4 cycles per element; the first BRAM_EN SHALL appear the cycle after start.
REQ-024 In every state other than RD_A, RD_B and WR, BRAM_EN=0, BRAM_WE=0 and BRAM_ADDR holds its last value.
REQ-025 DONE: done=1, busy=0; done SHALL hold until start=1 (new operation accepted, done cleared the same edge) or reset.
REQ-026 start while busy SHALL be ignored; len and base changes while busy SHALL have no effect.
REQ-027 Aliased regions (base_c equal to base_a or base_b) SHALL produce in-place results, because each C[i] write follows both reads of element i.

Reset
REQ-028 On BRAM_RST=1 at a rising edge, the state SHALL return to IDLE and all outputs SHALL become 0 (BRAM_ADDR, BRAM_WRDATA, BRAM_EN, BRAM_WE, busy, done).
REQ-029 Reset mid-operation SHALL abort at once with no further BRAM access; the partial result region is undefined.

Configuration
REQ-030 With macro BRAM_VEC_SAT_EN defined, the addition SHALL be signed 32-bit saturating (clamp to 32'h7FFFFFFF / 32'h80000000).
REQ-031 Without BRAM_VEC_SAT_EN, the addition SHALL be modulo 2^32 (carry discarded).

Structure
REQ-032 Package bram_pkg SHALL hold the FSM state encoding, the word size constant (4 bytes) and the saturation limits.
REQ-033 The adder (wrap or saturating, macro-selected) SHALL be a sub-module named vec_add32.

Verification
REQ-034 len=4, base_a=0x0000, base_b=0x0100, base_c=0x0200, A={1,2,3,4}, B={10,20,30,40} -> C={11,22,33,44}, done high 17 cycles after start.
REQ-035 len=0, start=1 -> no BRAM_EN ever asserted, done=1 the cycle after start.
REQ-036 base_c=base_a=0x7FF8, len=4 -> addresses wrap 0x7FF8, 0x7FFC, 0x0000, 0x0004; A overwritten in place with the correct sums.
REQ-037 A[0]=0x7FFFFFFF, B[0]=1 -> C[0]=0x7FFFFFFF with BRAM_VEC_SAT_EN; C[0]=0x80000000 without.
REQ-038 BRAM_RST asserted in the WR cycle of element 2 of len=8 -> next cycle all outputs 0, IDLE, and no write to element 2.
REQ-039 Second start pulse during busy, then start after done -> first ignored; the second operation runs and done drops on the accepting edge.
